jk_button_sequencer: RTL and testbench
======================================

// Module: jk_button_sequencer
// PURPOSE
//  Front-end stage that drives the JK flip-flop's J/K/R/S command inputs from four raw board push-buttons.
//  Per-button: synchronise, debounce and detect the press edge.
//  A J press and a K press arriving within a short window pair into a single toggle command (J=K=1).
//  Emits one-cycle command pulses in the same clock domain as the flip-flop, plus a wrap-around count of issued commands.
// PARAMETERS
//  DEB_CYCLES  16  consecutive cycles a synchronised button must differ from its stable value before the stable value changes (>=2)
//  PAIR_WIN    8   cycles a lone J or K press waits for its partner before issuing alone (>=1)
//  CNT_W       8   width of CMD_CNT
// PORTS
//  CLK      in   1      single clock; all logic rising-edge
//  R        in   1      reset, synchronous, active-high
//  BTN_J    in   1      raw asynchronous button, high = pressed
//  BTN_K    in   1      raw asynchronous button
//  BTN_R    in   1      raw asynchronous button
//  BTN_S    in   1      raw asynchronous button
//  J_OUT    out  1      one-cycle J command to flip-flop
//  K_OUT    out  1      one-cycle K command
//  R_OUT    out  1      one-cycle reset command
//  S_OUT    out  1      one-cycle set command
//  CMD_CNT  out  CNT_W  number of command cycles issued, modulo 2^CNT_W
//  BUSY     out  1      high while FSM is in WAIT_PAIR
// BEHAVIOUR
//  Reset: all outputs 0; sync/stable/pulse regs 0; debounce counters 0; FSM=IDLE; pair timer 0.
//  Synchroniser: 2 FFs per button.
//  Debounce:
//   - Counter clears whenever synced==stable.
//   - Otherwise it increments; when it reaches DEB_CYCLES-1, stable<=synced and counter clears.
//  Edge: press pulse Px=1 for one cycle after stable rises 0->1. Release generates nothing.
//  Latency: a BTN held high from clock edge 0 gives Px at edge DEB_CYCLES+2. A command output asserts 1 cycle after its Px.
//  Glitch: any return to stable value before the count completes restarts the count; no pulse.
//  FSM, one decision per cycle, priority R > S > J/K:
//   - IDLE:
//     - PR -> R_OUT next cycle.
//     - Else PS -> S_OUT.
//     - Else PJ&PK same cycle -> J_OUT=K_OUT=1.
//     - Else a single PJ or PK -> latch which one, timer=PAIR_WIN-1, go to WAIT_PAIR.
//   - WAIT_PAIR:
//     - PR or PS -> issue it; the pending J/K is discarded; go to IDLE.
//     - Else partner pulse -> J_OUT=K_OUT=1, go to IDLE.
//     - Else same-letter pulse again -> ignored, timer not restarted.
//     - Else timer==0 -> issue the latched single command, go to IDLE.
//     - Else timer decrements.
//  Outputs: registered. At most one command cycle per clock. R_OUT and S_OUT are never high together and never high with J_OUT/K_OUT.
//  Dropped pulses: lower-priority pulses in the same cycle as a higher-priority one are dropped, not queued.
//  CMD_CNT: +1 on every cycle any *_OUT is high; wraps 2^CNT_W-1 -> 0.
//  Mid-operation reset: R during WAIT_PAIR or mid-debounce returns everything to the reset state next edge. A button still held after reset re-debounces and pulses once.
// STRUCTURE
//  Package jk_seq_pkg:
//   - FSM state typedef {IDLE, WAIT_PAIR}.
//   - Command encoding constants CMD_NONE/J/K/JK/R/S.
//  Sub-module btn_debounce (sync + debounce + rise pulse, parameter DEB_CYCLES), instantiated 4x.
//  Top holds the FSM, pair timer, output regs and CMD_CNT.
// TESTING (DEB_CYCLES=4, PAIR_WIN=3 unless noted)
//  1. BTN_S bounce 1,0,1,0 then held high 10 cycles -> exactly one S_OUT pulse, 1 cycle after PS; CMD_CNT 0->1.
//  2. BTN_J press, BTN_K press 2 cycles later -> single cycle J_OUT=K_OUT=1; no lone J_OUT; BUSY high 2 cycles.
//  3. BTN_K alone -> K_OUT asserted 3 cycles after entering WAIT_PAIR (timer expiry); BUSY then 0.
//  4. BTN_J, then BTN_R within window -> R_OUT only; J never issued; FSM IDLE.
//  5. PR, PS, PJ same cycle -> only R_OUT; CNT_W=2 with 5 commands -> CMD_CNT reads 1.
//  6. Assert R during WAIT_PAIR -> next cycle all outputs 0, BUSY 0, CMD_CNT 0, no pending command issued.

Source files
------------

// File: rtl/jk_seq_pkg.sv
// Shared types for the JK push-button command sequencer: FSM states,
// internal command encoding and the decode from a command to the four
// flip-flop command lines.
package jk_seq_pkg;

    // Pairing FSM: either idle or holding a lone J/K press for its partner.
    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_PAIR = 1'b1
    } state_e;

    // Internal command encoding carried between decision and output stage.
    typedef logic [2:0] cmd_t;

    localparam cmd_t CMD_NONE = 3'd0;
    localparam cmd_t CMD_J    = 3'd1;
    localparam cmd_t CMD_K    = 3'd2;
    localparam cmd_t CMD_JK   = 3'd3;
    localparam cmd_t CMD_R    = 3'd4;
    localparam cmd_t CMD_S    = 3'd5;

    // One bit per flip-flop command input.
    typedef struct packed {
        logic j;
        logic k;
        logic r;
        logic s;
    } cmd_lines_t;

    // Expand an encoded command onto the flip-flop command lines.
    function automatic cmd_lines_t cmd_lines(input cmd_t cmd);
        cmd_lines_t lines;
        lines = '0;
        case (cmd)
            CMD_J:   lines.j = 1'b1;
            CMD_K:   lines.k = 1'b1;
            CMD_JK:  begin
                lines.j = 1'b1;
                lines.k = 1'b1;
            end
            CMD_R:   lines.r = 1'b1;
            CMD_S:   lines.s = 1'b1;
            default: lines = '0;
        endcase
        return lines;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: two-flop synchroniser, counting debouncer
// and a single-cycle pulse on each debounced press (release is silent).
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_dly_q;
    logic             pulse_q;
    logic [CNT_W-1:0] cnt_q;

    // Synchronise, require DEB_CYCLES consecutive differing samples before
    // accepting a new level, then flag the 0->1 transition of that level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            pulse_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;

            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                stable_q <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            stable_dly_q <= stable_q;
            pulse_q      <= stable_q & ~stable_dly_q;
        end
    end

    assign press_o = pulse_q;

endmodule

// File: rtl/jk_button_sequencer.sv
// Turns four raw push-buttons into one-cycle J/K/R/S commands for the JK
// flip-flop. A J and a K press close together merge into one toggle
// (J=K=1); R beats S beats J/K; a running count of command cycles is kept.
module jk_button_sequencer
    import jk_seq_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned PAIR_WIN   = 8,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             BTN_J,
    input  logic             BTN_K,
    input  logic             BTN_R,
    input  logic             BTN_S,
    output logic             J_OUT,
    output logic             K_OUT,
    output logic             R_OUT,
    output logic             S_OUT,
    output logic [CNT_W-1:0] CMD_CNT,
    output logic             BUSY
);

    localparam int unsigned TMR_W = (PAIR_WIN > 1) ? $clog2(PAIR_WIN) : 1;

    logic press_j;
    logic press_k;
    logic press_r;
    logic press_s;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_j (
        .clk_i   (CLK),
        .rst_i   (R),
        .btn_i   (BTN_J),
        .press_o (press_j)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_k (
        .clk_i   (CLK),
        .rst_i   (R),
        .btn_i   (BTN_K),
        .press_o (press_k)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_r (
        .clk_i   (CLK),
        .rst_i   (R),
        .btn_i   (BTN_R),
        .press_o (press_r)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_s (
        .clk_i   (CLK),
        .rst_i   (R),
        .btn_i   (BTN_S),
        .press_o (press_s)
    );

    state_e             state_q;
    state_e             state_d;
    cmd_t               pend_q;
    cmd_t               pend_d;
    logic [TMR_W-1:0]   timer_q;
    logic [TMR_W-1:0]   timer_d;
    cmd_t               cmd_d;
    cmd_lines_t         lines_q;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               partner_c;

    // The press that completes the pending one: K completes J, J completes K.
    assign partner_c = (pend_q == CMD_J) ? press_k : press_j;

    // Per-cycle decision: at most one command, R > S > J/K pairing.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        timer_d = timer_q;
        cmd_d   = CMD_NONE;

        case (state_q)
            IDLE: begin
                if (press_r) begin
                    cmd_d = CMD_R;
                end else if (press_s) begin
                    cmd_d = CMD_S;
                end else if (press_j && press_k) begin
                    cmd_d = CMD_JK;
                end else if (press_j || press_k) begin
                    pend_d  = press_j ? CMD_J : CMD_K;
                    timer_d = TMR_W'(PAIR_WIN - 1);
                    state_d = WAIT_PAIR;
                end
            end

            WAIT_PAIR: begin
                if (press_r) begin
                    cmd_d   = CMD_R;
                    pend_d  = CMD_NONE;
                    state_d = IDLE;
                end else if (press_s) begin
                    cmd_d   = CMD_S;
                    pend_d  = CMD_NONE;
                    state_d = IDLE;
                end else if (partner_c) begin
                    cmd_d   = CMD_JK;
                    pend_d  = CMD_NONE;
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    // A repeated same-letter press falls through to here and
                    // does not restart the window.
                    cmd_d   = pend_q;
                    pend_d  = CMD_NONE;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end

            default: begin
                pend_d  = CMD_NONE;
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // FSM, pair timer, registered command lines, BUSY and command counter.
    always_ff @(posedge CLK) begin
        if (R) begin
            state_q <= IDLE;
            pend_q  <= CMD_NONE;
            timer_q <= '0;
            lines_q <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            timer_q <= timer_d;
            lines_q <= cmd_lines(cmd_d);
            busy_q  <= (state_d == WAIT_PAIR);
            if (cmd_d != CMD_NONE) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign J_OUT   = lines_q.j;
    assign K_OUT   = lines_q.k;
    assign R_OUT   = lines_q.r;
    assign S_OUT   = lines_q.s;
    assign BUSY    = busy_q;
    assign CMD_CNT = cnt_q;

endmodule

// File: tb/tb_jk_button_sequencer.sv
// Bench for jk_button_sequencer: directed scenarios followed by random button
// activity, all checked cycle by cycle against a behavioural model.
module tb_jk_button_sequencer;

    localparam int DEB = 4;
    localparam int WIN = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic bj, bk, br, bs;

    logic       j8, k8, r8, s8, busy8;
    logic [7:0] cnt8;
    logic       j2, k2, r2, s2, busy2;
    logic [1:0] cnt2;

    jk_button_sequencer #(.DEB_CYCLES(DEB), .PAIR_WIN(WIN), .CNT_W(8)) u_dut8 (
        .CLK(clk), .R(rst), .BTN_J(bj), .BTN_K(bk), .BTN_R(br), .BTN_S(bs),
        .J_OUT(j8), .K_OUT(k8), .R_OUT(r8), .S_OUT(s8), .CMD_CNT(cnt8), .BUSY(busy8)
    );

    jk_button_sequencer #(.DEB_CYCLES(DEB), .PAIR_WIN(WIN), .CNT_W(2)) u_dut2 (
        .CLK(clk), .R(rst), .BTN_J(bj), .BTN_K(bk), .BTN_R(br), .BTN_S(bs),
        .J_OUT(j2), .K_OUT(k2), .R_OUT(r2), .S_OUT(s2), .CMD_CNT(cnt2), .BUSY(busy2)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model. Buttons indexed 0=J 1=K 2=R 3=S.
    // A button's level becomes stable after DEB consecutive sampled edges
    // that disagree with it; the sampled value lags the pin by two edges and
    // the command decision sees a new stable high two edges later.
    int unsigned step_n;
    logic [3:0]  m_d1, m_d2, m_stab, m_rose1, m_rose2;
    int          m_run [4];
    int          m_pend;        // 0 none, 1 J waiting, 2 K waiting
    int unsigned m_deadline;    // edge at which a lone J/K is issued
    logic [3:0]  e_lines;       // {j,k,r,s} expected after this edge
    int unsigned e_cnt;

    task automatic model_reset();
        m_d1 = '0; m_d2 = '0; m_stab = '0; m_rose1 = '0; m_rose2 = '0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_pend = 0; m_deadline = 0; e_lines = '0; e_cnt = 0;
    endtask

    task automatic model_step(input logic [3:0] b, input logic rst_in);
        logic [3:0] p;
        logic [3:0] rose_now;
        step_n++;
        if (rst_in) begin
            model_reset();
            return;
        end
        p       = m_rose2;
        e_lines = '0;
        if (p[2]) begin
            e_lines = 4'b0010; m_pend = 0;
        end else if (p[3]) begin
            e_lines = 4'b0001; m_pend = 0;
        end else if (m_pend == 0) begin
            if (p[0] && p[1])  e_lines = 4'b1100;
            else if (p[0]) begin m_pend = 1; m_deadline = step_n + WIN; end
            else if (p[1]) begin m_pend = 2; m_deadline = step_n + WIN; end
        end else if ((m_pend == 1 && p[1]) || (m_pend == 2 && p[0])) begin
            e_lines = 4'b1100; m_pend = 0;
        end else if (step_n == m_deadline) begin
            e_lines = (m_pend == 1) ? 4'b1000 : 4'b0100;
            m_pend  = 0;
        end
        if (e_lines != 4'b0000) e_cnt++;

        rose_now = '0;
        for (int i = 0; i < 4; i++) begin
            if (m_d2[i] != m_stab[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_stab[i]   = m_d2[i];
                    m_run[i]    = 0;
                    rose_now[i] = m_d2[i];
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_rose2 = m_rose1;
        m_rose1 = rose_now;
        m_d2    = m_d1;
        m_d1    = b;
    endtask

    // Observed command activity within the current scenario.
    int unsigned o_j, o_k, o_jk, o_r, o_s, o_busy;

    task automatic clr_obs();
        o_j = 0; o_k = 0; o_jk = 0; o_r = 0; o_s = 0; o_busy = 0;
    endtask

    // One clock: drive on the falling edge, step the model on the rising
    // edge, compare both instances shortly after.
    task automatic cycle(input logic [3:0] b, input logic rst_in);
        @(negedge clk);
        bj = b[0]; bk = b[1]; br = b[2]; bs = b[3]; rst = rst_in;
        @(posedge clk);
        model_step(b, rst_in);
        #1;
        chk("flags8", 32'({j8, k8, r8, s8, busy8}), 32'({e_lines, (m_pend != 0)}));
        chk("cnt8",   32'(cnt8), e_cnt % 256);
        chk("flags2", 32'({j2, k2, r2, s2, busy2}), 32'({e_lines, (m_pend != 0)}));
        chk("cnt2",   32'(cnt2), e_cnt % 4);
        if (j8 && k8)  o_jk++;
        else if (j8)   o_j++;
        else if (k8)   o_k++;
        if (r8)        o_r++;
        if (s8)        o_s++;
        if (busy8)     o_busy++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(4'b0000, 1'b0);
    endtask

    logic [3:0] rb;
    int         guard;

    initial begin
        step_n = 0;
        model_reset();
        clr_obs();
        rst = 1'b1; bj = 1'b0; bk = 1'b0; br = 1'b0; bs = 1'b0;

        for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b1);
        chk("reset_flags", 32'({j8, k8, r8, s8, busy8}), 32'd0);
        chk("reset_cnt",   32'(cnt8), 32'd0);

        // Bounced S press then a clean hold: one S command.
        clr_obs();
        cycle(4'b1000, 1'b0); cycle(4'b0000, 1'b0);
        cycle(4'b1000, 1'b0); cycle(4'b0000, 1'b0);
        for (int i = 0; i < 10; i++) cycle(4'b1000, 1'b0);
        idle(15);
        chk("t1_s_pulses", o_s, 1);
        chk("t1_cnt", 32'(cnt8), 1);

        // J then K two cycles later: one toggle, BUSY for two cycles.
        clr_obs();
        cycle(4'b0001, 1'b0); cycle(4'b0001, 1'b0);
        for (int i = 0; i < 10; i++) cycle(4'b0011, 1'b0);
        idle(15);
        chk("t2_jk", o_jk, 1);
        chk("t2_lone_j", o_j, 0);
        chk("t2_busy_cycles", o_busy, 2);

        // Lone K: issued on window expiry.
        clr_obs();
        for (int i = 0; i < 8; i++) cycle(4'b0010, 1'b0);
        idle(15);
        chk("t3_k", o_k, 1);
        chk("t3_busy_cycles", o_busy, WIN);
        chk("t3_busy_end", 32'(busy8), 0);

        // J then R inside the window: R only.
        clr_obs();
        cycle(4'b0001, 1'b0); cycle(4'b0001, 1'b0);
        for (int i = 0; i < 8; i++) cycle(4'b0101, 1'b0);
        idle(15);
        chk("t4_r", o_r, 1);
        chk("t4_j", o_j + o_jk, 0);
        chk("t4_busy_end", 32'(busy8), 0);

        // R, S and J together: R wins, the rest are dropped.
        clr_obs();
        for (int i = 0; i < 8; i++) cycle(4'b1101, 1'b0);
        idle(15);
        chk("t5_r", o_r, 1);
        chk("t5_s", o_s, 0);
        chk("t5_j", o_j + o_jk, 0);
        chk("t5_cnt_w2", 32'(cnt2), 1);
        chk("t5_cnt_w8", 32'(cnt8), 5);

        // Reset while a lone J is pending: nothing is ever issued.
        clr_obs();
        guard = 0;
        while (!busy8 && guard < 20) begin
            cycle(4'b0001, 1'b0);
            guard++;
        end
        chk("t6_busy_seen", 32'(busy8), 1);
        cycle(4'b0000, 1'b1);
        chk("t6_flags", 32'({j8, k8, r8, s8, busy8}), 32'd0);
        chk("t6_cnt", 32'(cnt8), 0);
        idle(15);
        chk("t6_no_cmd", o_j + o_k + o_jk + o_r + o_s, 0);

        // Random activity with occasional resets.
        rb = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 11) == 0) rb[i] = ~rb[i];
            cycle(rb, ($urandom_range(0, 599) == 0));
        end
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
